// File: rtl/tone_detector.sv
// rtl/tone_detector.sv - square-wave period / high-time meter with no-tone timeout.
// Define TONE_DETECT_MATCH_EN to add the target_period match flag.
module tone_detector #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1000000,
   parameter int TOL     = 16
) (
   input  logic             hwclk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic [CNT_W-1:0] target_period,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             no_tone,
   output logic             match
);
   typedef enum logic [1:0] {NO_SIGNAL, ARMED, MEASURE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic             s1, s2, s3;
   logic             rise, fall;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             load_period, load_high, timeout;

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise    = s2 & ~s3;
   assign fall    = ~s2 & s3;
   assign cnt_inc = cnt + 1'b1;

   // cnt holds (cycles since last rise) - 1, so cnt+1 is the measured length
   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt_inc;
      end
   end

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         state <= NO_SIGNAL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      load_period = 1'b0;
      load_high   = 1'b0;
      timeout     = 1'b0;
      case (state)
         NO_SIGNAL: begin
            if (rise) state_nxt = ARMED;
         end
         ARMED, MEASURE: begin
            load_high = fall;
            if (rise) begin
               state_nxt   = MEASURE;
               load_period = 1'b1;
            end else if (cnt == CNT_MAX) begin
               state_nxt = NO_SIGNAL;
               timeout   = 1'b1;
            end
         end
         default: state_nxt = NO_SIGNAL;
      endcase
   end

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         period       <= '0;
         high_time    <= '0;
         period_valid <= 1'b0;
         no_tone      <= 1'b1;
      end else begin
         period_valid <= load_period;
         if (load_period) period <= cnt_inc;
         if (load_high) high_time <= cnt_inc;
         if (timeout) begin
            no_tone <= 1'b1;
         end else if (load_period) begin
            no_tone <= 1'b0;
         end
      end
   end

`ifdef TONE_DETECT_MATCH_EN
   logic [CNT_W:0] period_new;
   logic [CNT_W:0] target_ext;
   logic [CNT_W:0] diff;

   assign period_new = {1'b0, cnt} + 1'b1;
   assign target_ext = {1'b0, target_period};
   assign diff       = (period_new >= target_ext) ? (period_new - target_ext)
                                                  : (target_ext - period_new);

   always_ff @(posedge hwclk or posedge rst) begin
      if (rst) begin
         match <= 1'b0;
      end else if (timeout) begin
         match <= 1'b0;
      end else if (load_period) begin
         match <= (diff <= (CNT_W+1)'(TOL));
      end
   end
`else
   localparam int unused_tol = TOL;
   logic unused_target;

   assign unused_target = ^target_period;
   assign match         = 1'b0;
`endif

endmodule
